// File: rtl/tff_counter_pkg.sv
// Shared types for the tff_counter family: counting mode encoding.
package tff_counter_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_TOGGLE = 2'b11
   } mode_e;

endpackage

// File: rtl/tff_counter_if.sv
// Control/status bundle between a counter user (master) and the tff_counter (slave).
interface tff_counter_if #(
   parameter int WIDTH = 8
);
   logic             sclr;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] t_in;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             ovf;

   modport master (
      output sclr, en, mode, t_in, load, load_val,
      input  q, tc, wrap, ovf
   );

   modport slave (
      input  sclr, en, mode, t_in, load, load_val,
      output q, tc, wrap, ovf
   );
endinterface

// File: rtl/tff_counter_bit.sv
// Single T flip-flop with async clear, plus synchronous clear and load.
module tff_bit (
   input  logic clk,
   input  logic clr,
   input  logic sclr,
   input  logic ld,
   input  logic d,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr)       q <= 1'b0;
      else if (sclr) q <= 1'b0;
      else if (ld)   q <= d;
      else           q <= q ^ t;
   end

endmodule

// File: rtl/tff_counter.sv
// Parametrised T-flip-flop counter bank: hold / up / down / raw toggle with optional
// modulus, sync clear/load, terminal count, wrap pulse and sticky overflow.
module tff_counter
   import tff_counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 0
) (
   input logic           clk,
   input logic           clr,
   tff_counter_if.slave  bus
);

   if (WIDTH < 1 || MODULUS < 0 || MODULUS == 1 ||
       longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_param_err
      $error("tff_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end

   localparam logic [WIDTH-1:0] MAXV = (MODULUS == 0) ? {WIDTH{1'b1}}
                                                      : WIDTH'(MODULUS - 1);

   mode_e            m;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] nq;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] ld_val;
   logic             ld_clamp;
   logic             nwrap;
   logic             novr;
   logic             wrap_r;
   logic             ovf_r;

   assign m        = mode_e'(bus.mode);
   assign ld_clamp = (bus.load_val > MAXV);
   assign ld_val   = ld_clamp ? MAXV : bus.load_val;
   assign r        = q ^ bus.t_in;

   always_comb begin
      nq    = q;
      nwrap = 1'b0;
      novr  = 1'b0;
      if (bus.en) begin
         case (m)
            MODE_UP: begin
               if (q == MAXV) begin
                  nq    = '0;
                  nwrap = 1'b1;
               end else begin
                  nq = q + 1'b1;
               end
            end
            MODE_DOWN: begin
               if (q == '0) begin
                  nq    = MAXV;
                  nwrap = 1'b1;
               end else begin
                  nq = q - 1'b1;
               end
            end
            MODE_TOGGLE: begin
               // Only a truncated modulus can leave the legal range via raw toggles.
               if (MODULUS != 0 && r > MAXV) begin
                  nq    = '0;
                  nwrap = 1'b1;
                  novr  = 1'b1;
               end else begin
                  nq = r;
               end
            end
            default: ;
         endcase
      end
   end

   // Each cell toggles exactly where the chosen next state differs from the present one.
   assign t_vec = q ^ nq;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_bit u_bit (
         .clk  (clk),
         .clr  (clr),
         .sclr (bus.sclr),
         .ld   (bus.load),
         .d    (ld_val[i]),
         .t    (t_vec[i]),
         .q    (q[i])
      );
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wrap_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (bus.sclr) begin
         wrap_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (bus.load) begin
         wrap_r <= 1'b0;
         ovf_r  <= ovf_r | ld_clamp;
      end else begin
         wrap_r <= nwrap;
         ovf_r  <= ovf_r | novr;
      end
   end

   assign bus.q    = q;
   assign bus.wrap = wrap_r;
   assign bus.ovf  = ovf_r;
   assign bus.tc   = bus.en & (((m == MODE_UP)   && (q == MAXV)) ||
                               ((m == MODE_DOWN) && (q == '0)));

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: a WIDTH=4/MODULUS=10 instance and a natural-modulus instance.
module tb_tff_counter;

   logic clk = 1'b0;
   logic clr = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tff_counter_if #(.WIDTH(4)) ia ();
   tff_counter_if #(.WIDTH(4)) ib ();

   tff_counter #(.WIDTH(4), .MODULUS(10)) dut_a (.clk(clk), .clr(clr), .bus(ia));
   tff_counter #(.WIDTH(4), .MODULUS(0))  dut_b (.clk(clk), .clr(clr), .bus(ib));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ia.sclr = 0; ia.en = 0; ia.mode = 2'b00; ia.t_in = 4'd0; ia.load = 0; ia.load_val = 4'd0;
      ib.sclr = 0; ib.en = 0; ib.mode = 2'b00; ib.t_in = 4'd0; ib.load = 0; ib.load_val = 4'd0;
   endtask

   task automatic test_reset();
      idle_all();
      clr = 1; #3; clr = 0;
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL reset_init_q got %0d exp 0", ia.q); end
      ia.load = 1; ia.load_val = 4'd12;
      step();
      ia.load = 0;
      checks++; if (ia.q !== 4'd9) begin errors++; $display("FAIL pre_clr_q got %0d exp 9", ia.q); end
      checks++; if (ia.ovf !== 1'b1) begin errors++; $display("FAIL pre_clr_ovf got %0b exp 1", ia.ovf); end
      #2; clr = 1; #1;
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL async_clr_q got %0d exp 0", ia.q); end
      checks++; if (ia.ovf !== 1'b0) begin errors++; $display("FAIL async_clr_ovf got %0b exp 0", ia.ovf); end
      checks++; if (ia.wrap !== 1'b0) begin errors++; $display("FAIL async_clr_wrap got %0b exp 0", ia.wrap); end
      #1; clr = 0;
   endtask

   task automatic test_up();
      logic [3:0] exp_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      logic [3:0] cur = 4'd0;
      ia.en = 1; ia.mode = 2'b01;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (ia.tc !== (cur == 4'd9)) begin
            errors++; $display("FAIL up_tc step %0d got %0b exp %0b", k, ia.tc, (cur == 4'd9));
         end
         step();
         checks++;
         if (ia.q !== exp_q[k]) begin errors++; $display("FAIL up_q step %0d got %0d exp %0d", k, ia.q, exp_q[k]); end
         checks++;
         if (ia.wrap !== (k == 9)) begin errors++; $display("FAIL up_wrap step %0d got %0b exp %0b", k, ia.wrap, (k == 9)); end
         cur = exp_q[k];
      end
      ia.en = 0;
      step();
      checks++; if (ia.q !== 4'd2) begin errors++; $display("FAIL up_hold_q got %0d exp 2", ia.q); end
      checks++; if (ia.tc !== 1'b0) begin errors++; $display("FAIL up_hold_tc got %0b exp 0", ia.tc); end
   endtask

   task automatic test_down();
      ib.load = 1; ib.load_val = 4'd1;
      step();
      ib.load = 0; ib.en = 1; ib.mode = 2'b10; #1;
      checks++; if (ib.q !== 4'd1) begin errors++; $display("FAIL dn_load_q got %0d exp 1", ib.q); end
      checks++; if (ib.tc !== 1'b0) begin errors++; $display("FAIL dn_tc_at1 got %0b exp 0", ib.tc); end
      step();
      checks++; if (ib.q !== 4'd0) begin errors++; $display("FAIL dn_q0 got %0d exp 0", ib.q); end
      checks++; if (ib.tc !== 1'b1) begin errors++; $display("FAIL dn_tc_at0 got %0b exp 1", ib.tc); end
      checks++; if (ib.wrap !== 1'b0) begin errors++; $display("FAIL dn_wrap_early got %0b exp 0", ib.wrap); end
      step();
      checks++; if (ib.q !== 4'd15) begin errors++; $display("FAIL dn_q15 got %0d exp 15", ib.q); end
      checks++; if (ib.wrap !== 1'b1) begin errors++; $display("FAIL dn_wrap got %0b exp 1", ib.wrap); end
      checks++; if (ib.ovf !== 1'b0) begin errors++; $display("FAIL dn_ovf got %0b exp 0", ib.ovf); end
      step();
      checks++; if (ib.q !== 4'd14) begin errors++; $display("FAIL dn_q14 got %0d exp 14", ib.q); end
      checks++; if (ib.wrap !== 1'b0) begin errors++; $display("FAIL dn_wrap_clear got %0b exp 0", ib.wrap); end
      ib.en = 0;
   endtask

   task automatic test_load_clamp();
      ia.load = 1; ia.load_val = 4'd7;
      step();
      checks++; if (ia.q !== 4'd7) begin errors++; $display("FAIL ld7_q got %0d exp 7", ia.q); end
      checks++; if (ia.ovf !== 1'b0) begin errors++; $display("FAIL ld7_ovf got %0b exp 0", ia.ovf); end
      ia.load_val = 4'd12;
      step();
      ia.load = 0;
      checks++; if (ia.q !== 4'd9) begin errors++; $display("FAIL ld12_q got %0d exp 9", ia.q); end
      checks++; if (ia.ovf !== 1'b1) begin errors++; $display("FAIL ld12_ovf got %0b exp 1", ia.ovf); end
      ia.en = 1; ia.mode = 2'b01;
      step();
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL ldcnt_q got %0d exp 0", ia.q); end
      checks++; if (ia.wrap !== 1'b1) begin errors++; $display("FAIL ldcnt_wrap got %0b exp 1", ia.wrap); end
      step();
      checks++; if (ia.q !== 4'd1) begin errors++; $display("FAIL ldcnt2_q got %0d exp 1", ia.q); end
      checks++; if (ia.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", ia.ovf); end
      ia.en = 0; ia.sclr = 1;
      step();
      ia.sclr = 0;
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL sclr_q got %0d exp 0", ia.q); end
      checks++; if (ia.ovf !== 1'b0) begin errors++; $display("FAIL sclr_ovf got %0b exp 0", ia.ovf); end
   endtask

   task automatic test_toggle();
      ia.load = 1; ia.load_val = 4'd5;
      step();
      ia.load = 0; ia.en = 1; ia.mode = 2'b11; ia.t_in = 4'b0011;
      step();
      checks++; if (ia.q !== 4'd6) begin errors++; $display("FAIL tog_q6 got %0d exp 6", ia.q); end
      checks++; if (ia.tc !== 1'b0) begin errors++; $display("FAIL tog_tc got %0b exp 0", ia.tc); end
      checks++; if (ia.wrap !== 1'b0) begin errors++; $display("FAIL tog_wrap0 got %0b exp 0", ia.wrap); end
      ia.t_in = 4'b1100;
      step();
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL tog_ovr_q got %0d exp 0", ia.q); end
      checks++; if (ia.wrap !== 1'b1) begin errors++; $display("FAIL tog_ovr_wrap got %0b exp 1", ia.wrap); end
      checks++; if (ia.ovf !== 1'b1) begin errors++; $display("FAIL tog_ovr_ovf got %0b exp 1", ia.ovf); end
      ia.t_in = 4'b0000;
      step();
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL tog_hold_q got %0d exp 0", ia.q); end
      checks++; if (ia.wrap !== 1'b0) begin errors++; $display("FAIL tog_hold_wrap got %0b exp 0", ia.wrap); end
      ia.t_in = 4'b1001;
      step();
      checks++; if (ia.q !== 4'd9) begin errors++; $display("FAIL tog_q9 got %0d exp 9", ia.q); end
      ia.en = 0; ia.t_in = 4'd0;
   endtask

   task automatic test_priority();
      ia.sclr = 1; ia.load = 1; ia.load_val = 4'd7; ia.en = 1; ia.mode = 2'b01;
      step();
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL prio_sclr_q got %0d exp 0", ia.q); end
      checks++; if (ia.ovf !== 1'b0) begin errors++; $display("FAIL prio_sclr_ovf got %0b exp 0", ia.ovf); end
      ia.sclr = 0; ia.load_val = 4'd4;
      step();
      checks++; if (ia.q !== 4'd4) begin errors++; $display("FAIL prio_load_q got %0d exp 4", ia.q); end
      ia.load = 0; ia.mode = 2'b10;
      step();
      checks++; if (ia.q !== 4'd3) begin errors++; $display("FAIL mode_switch_q got %0d exp 3", ia.q); end
      ia.mode = 2'b01;
      for (int k = 0; k < 3; k++) step();
      checks++; if (ia.q !== 4'd6) begin errors++; $display("FAIL pre_clr_count_q got %0d exp 6", ia.q); end
      #2; clr = 1; #1;
      checks++; if (ia.q !== 4'd0) begin errors++; $display("FAIL midcount_clr_q got %0d exp 0", ia.q); end
      #1; clr = 0;
      step();
      checks++; if (ia.q !== 4'd1) begin errors++; $display("FAIL resume1_q got %0d exp 1", ia.q); end
      step();
      checks++; if (ia.q !== 4'd2) begin errors++; $display("FAIL resume2_q got %0d exp 2", ia.q); end
      ia.en = 0;
   endtask

   initial begin
      test_reset();
      test_up();
      test_down();
      test_load_clamp();
      test_toggle();
      test_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
